// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller for the MW stage.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl #(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned SET_ADDR_LEN  = 4,
  parameter int unsigned TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
  input  logic        clk,
  input  logic        CpuRst,
`ifdef DCACHE_STATS_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned LineWords = 1 << LINE_ADDR_LEN;
  localparam int unsigned NumSets   = 1 << SET_ADDR_LEN;

  typedef enum logic [1:0] {StIdle, StWb, StRefill, StDone} state_e;

  state_e                    state_q, state_d;
  logic [LINE_ADDR_LEN-1:0]  cnt_q, cnt_d;
  logic [NumSets-1:0]        valid_q, dirty_q;
  logic [TAG_ADDR_LEN-1:0]   tag_q  [NumSets];
  logic [31:0]               data_q [NumSets][LineWords];
  // Victim/fill line captured at miss time so a dropped request cannot redirect the fill.
  logic [SET_ADDR_LEN-1:0]   miss_set_q;
  logic [TAG_ADDR_LEN-1:0]   miss_tag_q;

  logic [LINE_ADDR_LEN-1:0]  offset;
  logic [SET_ADDR_LEN-1:0]   set;
  logic [TAG_ADDR_LEN-1:0]   tag;
  logic                      req, hit, wr_hit, start_miss, refill_wr, line_done;
  logic                      unused_addr;

  assign offset      = addr[LINE_ADDR_LEN+1:2];
  assign set         = addr[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
  assign tag         = addr[31 -: TAG_ADDR_LEN];
  assign unused_addr = ^addr[1:0];

  assign req     = (rd_req | wr_req) & ~CpuRst;
  assign hit     = req & (state_q == StIdle) & valid_q[set] & (tag_q[set] == tag);
  assign wr_hit  = hit & wr_req;
  assign miss    = req & ~hit;
  assign rd_data = CpuRst ? 32'h0 : data_q[set][offset];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    start_miss = 1'b0;
    refill_wr  = 1'b0;
    line_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (miss) begin
          start_miss = 1'b1;
          cnt_d      = '0;
          state_d    = (valid_q[set] & dirty_q[set]) ? StWb : StRefill;
        end
      end
      StWb: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[miss_set_q], miss_set_q, cnt_q, 2'b00};
        mem_wdata = data_q[miss_set_q][cnt_q];
        if (mem_ack) begin
          if (&cnt_q) begin
            cnt_d   = '0;
            state_d = StRefill;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StRefill: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag_q, miss_set_q, cnt_q, 2'b00};
        if (mem_ack) begin
          refill_wr = 1'b1;
          if (&cnt_q) begin
            line_done = 1'b1;
            cnt_d     = '0;
            state_d   = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (CpuRst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_set_q <= '0;
      miss_tag_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start_miss) begin
        miss_set_q <= set;
        miss_tag_q <= tag;
      end
      if (wr_hit) dirty_q[set] <= 1'b1;
      if (line_done) begin
        valid_q[miss_set_q] <= 1'b1;
        dirty_q[miss_set_q] <= 1'b0;
        tag_q[miss_set_q]   <= miss_tag_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!CpuRst) begin
      if (refill_wr) begin
        data_q[miss_set_q][cnt_q] <= mem_rdata;
      end else if (wr_hit) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_be[b]) data_q[set][offset][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  // Marks the cycle where a stalled request finally hits; that hit belongs to the miss.
  logic        post_miss_q;

  always_ff @(posedge clk) begin
    if (CpuRst) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      post_miss_q <= 1'b0;
    end else begin
      post_miss_q <= (state_q == StDone) & req;
      if (hit & ~post_miss_q) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (start_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a word-serial memory responder of configurable ack delay.
module tb_dcache_ctrl;

  logic        clk;
  logic        CpuRst;
  logic        rd_req, wr_req;
  logic [31:0] addr, wr_data;
  logic [3:0]  wr_be;
  logic [31:0] rd_data;
  logic        miss;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_ctrl dut (
    .clk       (clk),
    .CpuRst    (CpuRst),
`ifdef DCACHE_STATS_EN
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
`endif
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .addr      (addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .rd_data   (rd_data),
    .miss      (miss),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Memory: word i initialised to 0x1000_0000 | i.
  logic [31:0] mem [1024];
  logic [31:0] log_addr [$];
  logic        log_we   [$];
  logic [31:0] log_data [$];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic        slow_chk  = 1'b0;
  logic [31:0] held_addr;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | i;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
  end

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      if (slow_chk && wait_cnt > 0) begin
        check("addr_stable", mem_addr, held_addr);
        check("miss_held", {31'b0, miss}, 32'h1);
      end
      held_addr = mem_addr;
      if (wait_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
        else        mem_rdata = mem[mem_addr[11:2]];
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_data.push_back(mem_we ? mem_wdata : mem[mem_addr[11:2]]);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_data.delete();
  endtask

  task automatic wait_miss(output int cycles);
    cycles = 0;
    while (miss && cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (miss) check("miss_timeout", {31'b0, miss}, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int lat;

  initial begin
    CpuRst = 1'b1;
    rd_req = 1'b0; wr_req = 1'b0;
    addr = 32'h0; wr_data = 32'h0; wr_be = 4'h0;
    tick(); tick();
    rd_req = 1'b1; addr = 32'h40;
    #1;
    check("rst_miss", {31'b0, miss}, 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    rd_req = 1'b0;
    tick();
    CpuRst = 1'b0;
    #1;
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);

    // Clean miss on 0x40: 8 reads, 8 acks + 2 cycles.
    clear_log();
    rd_req = 1'b1; addr = 32'h40;
    #1;
    check("miss_same_cycle", {31'b0, miss}, 32'h1);
    wait_miss(lat);
    check("lat_clean", lat, 32'd10);
    check("refill_cnt", log_addr.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("refill_addr", log_addr[i], 32'h40 + 4 * i);
      check("refill_we", {31'b0, log_we[i]}, 32'h0);
    end
    check("rd_0x40", rd_data, 32'h1000_0010);

    // Write hit on 0x44, low half only.
    clear_log();
    rd_req = 1'b0; wr_req = 1'b1; addr = 32'h44; wr_data = 32'hDEAD_BEEF; wr_be = 4'b0011;
    #1;
    check("wr_hit_miss", {31'b0, miss}, 32'h0);
    check("wr_hit_mem_req", {31'b0, mem_req}, 32'h0);
    tick();
    wr_req = 1'b0; rd_req = 1'b1; wr_be = 4'h0;
    #1;
    check("rd_after_wr_miss", {31'b0, miss}, 32'h0);
    check("rd_after_wr", rd_data, 32'h1000_BEEF);
    check("wr_no_traffic", log_addr.size(), 32'd0);

    // Dirty eviction: 0x440 maps to the same set with a new tag.
    addr = 32'h440;
    #1;
    check("evict_miss", {31'b0, miss}, 32'h1);
    wait_miss(lat);
    check("lat_dirty", lat, 32'd18);
    check("evict_cnt", log_addr.size(), 32'd16);
    for (int i = 0; i < 8; i++) begin
      check("wb_addr", log_addr[i], 32'h40 + 4 * i);
      check("wb_we", {31'b0, log_we[i]}, 32'h1);
      check("wb_data", log_data[i], (i == 1) ? 32'h1000_BEEF : 32'h1000_0010 + i);
      check("fill_addr", log_addr[8 + i], 32'h440 + 4 * i);
      check("fill_we", {31'b0, log_we[8 + i]}, 32'h0);
    end
    check("rd_0x440", rd_data, 32'h1000_0110);

    // Slow memory: 3 idle cycles per word, clean victim.
    clear_log();
    ack_delay = 3;
    slow_chk  = 1'b1;
    addr = 32'h840;
    #1;
    wait_miss(lat);
    slow_chk  = 1'b0;
    ack_delay = 0;
    check("lat_slow", lat, 32'd34);
    check("slow_cnt", log_addr.size(), 32'd8);
    check("slow_first", log_addr[0], 32'h840);
    check("rd_0x840", rd_data, 32'h1000_0210);

    // Reset during the 4th refill word; the ack coinciding with reset is dropped.
    rd_req = 1'b0;
    tick();
    clear_log();
    rd_req = 1'b1; addr = 32'h80;
    tick(); tick(); tick(); tick();
    CpuRst = 1'b1;
    tick();
    check("rst_mid_mem_req", {31'b0, mem_req}, 32'h0);
    CpuRst = 1'b0;
    #1;
    check("rst_refetch_miss", {31'b0, miss}, 32'h1);
    clear_log();
    wait_miss(lat);
    check("lat_refetch", lat, 32'd10);
    check("refetch_cnt", log_addr.size(), 32'd8);
    check("refetch_first", log_addr[0], 32'h80);
    check("refetch_last", log_addr[7], 32'h9C);
    check("rd_0x80", rd_data, 32'h1000_0020);

`ifdef DCACHE_STATS_EN
    rd_req = 1'b0;
    CpuRst = 1'b1;
    tick();
    CpuRst = 1'b0;
    #1;
    check("stats_rst_hit", hit_cnt, 32'd0);
    check("stats_rst_miss", miss_cnt, 32'd0);
    rd_req = 1'b1; addr = 32'hC0;
    #1;
    wait_miss(lat);
    tick();
    addr = 32'hC4; tick();
    addr = 32'hC8; tick();
    addr = 32'hCC; tick();
    rd_req = 1'b0;
    tick();
    check("stats_miss", miss_cnt, 32'd1);
    check("stats_hit", hit_cnt, 32'd3);
`endif

    rd_req = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache for the MW stage of the RISC-V pipeline.
- It is the producer of the DCacheMiss signal that the hazard logic consumes. It raises `miss` combinationally and holds it until the line is resident.
- It performs dirty-line writeback and line refill over a word-serial request/ack memory port.
- It relies on the stalled pipeline holding the CPU request stable until `miss` drops.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line (8 words).
- SET_ADDR_LEN, 4, log2 of number of lines (16 lines).
- TAG_ADDR_LEN, 32-2-LINE_ADDR_LEN-SET_ADDR_LEN (derived), tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- CpuRst  in  1  synchronous, active-high reset.
- rd_req  in  1  load in MW stage.
- wr_req  in  1  store in MW stage. rd_req and wr_req are never both 1.
- addr  in  32  byte address; bits [1:0] are ignored.
- wr_data  in  32  store data.
- wr_be  in  4  store byte enables.
- rd_data  out  32  load data; valid when rd_req=1 and miss=0.
- miss  out  1  DCacheMiss to the hazard unit.
- mem_req  out  1  memory word request.
- mem_we  out  1  1 = write word, 0 = read word.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  32  writeback word.
- mem_rdata  in  32  read word, valid with mem_ack.
- mem_ack  in  1  one-cycle completion of the current word.

Behaviour:
- Address split: offset=addr[LINE_ADDR_LEN+1:2], set=next SET_ADDR_LEN bits, tag=upper bits.
- Storage: per line, valid, dirty, tag and data words, all held in registers.
- Hit: (rd_req|wr_req) & state==IDLE & valid[set] & tag match.
- miss = (rd_req|wr_req) & ~hit. It is purely combinational, so it is asserted in the same cycle as the request. miss=1 in every non-IDLE state while a request is present.
- Read hit: rd_data = line word, combinational, zero extra latency. On a miss, rd_data is don't-care.
- Write hit: enabled bytes are written on the clock edge and dirty[set] is set. No memory traffic.
- FSM states: IDLE, WB, REFILL, DONE.
  - IDLE → WB on miss when valid & dirty; word counter cleared.
  - IDLE → REFILL on miss when the line is not dirty; word counter cleared.
  - WB: mem_req=1, mem_we=1, mem_addr={old tag, set, cnt, 2'b00}, mem_wdata=word[cnt]. On mem_ack, cnt increments. On the ack for the last word, cnt clears and the state goes to REFILL.
  - REFILL: mem_req=1, mem_we=0, mem_addr={new tag, set, cnt, 2'b00}. On mem_ack, word[cnt]=mem_rdata. On the last ack: tag updated, valid=1, dirty=0, state → DONE.
  - DONE: one cycle, miss stays 1, then → IDLE. The held request hits the cycle after.
- mem_req stays high, with stable addr/we/wdata, until mem_ack. mem_ack outside WB/REFILL is ignored.
- Word counter is LINE_ADDR_LEN bits wide and wraps only at the state exit.
- Miss latency, not dirty: 8 acks + 2 cycles.
- Miss latency, dirty: 16 acks + 2 cycles.
- A request that drops mid-refill (e.g. a flush) does not abort the fill. The line completes and the FSM returns to IDLE.
- Reset: state=IDLE, cnt=0, all valid=0, all dirty=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - miss=0 and rd_data=0 while CpuRst=1.
  - Tag/data contents are unspecified.
  - Reset mid-WB or mid-REFILL abandons the transfer: mem_req=0 the cycle after reset, and no partial line is marked valid.
- Simultaneous CpuRst and mem_ack: reset wins and the ack is dropped.

Optional Feature:
- DCACHE_STATS_EN.
  - Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0], both 0 on reset.
    - hit_cnt increments once per cycle with a hit whose request was not preceded by a miss.
    - miss_cnt increments once per IDLE→WB/REFILL transition.
    - Both wrap at 2^32.
  - Undefined: no ports, no counters, all other behaviour identical.

Test Plan:
- Reset, then rd_req addr=0x40 → miss=1 in the same cycle, 8 REFILL reads at 0x40..0x5C. After DONE, miss=0 and rd_data=mem[0x40].
- Write hit: wr_req addr=0x44, wr_data=0xDEADBEEF, wr_be=4'b0011 after the line is resident → miss=0, no mem_req. A following read of 0x44 returns {old[31:16],16'hBEEF}.
- Dirty eviction: after the write above, rd_req addr=0x440 (same set, new tag) → 8 writes to 0x40..0x5C first, with 0x44 carrying the updated word. Then 8 reads at 0x440..0x45C and rd_data correct.
- Slow memory: mem_ack delayed 3 cycles per word → mem_req/mem_addr stay stable while waiting and miss stays 1 throughout.
- CpuRst asserted during the 4th REFILL word → mem_req=0 next cycle. A subsequent read of the same address misses again and refills all 8 words.
- With DCACHE_STATS_EN: sequence of 1 miss, then 3 hits → miss_cnt=1, hit_cnt=3.
